// File: rtl/segment_text_scroller.sv
// segment_text_scroller
// Holds an ASCII message and scrolls a NUM_DIGITS-wide window across it,
// followed by NUM_DIGITS blanks before wrapping. Each window position is sent
// to a sixteen-segment display as one load pulse per digit, alternating with
// a gap cycle. After each frame the block idles for SCROLL_DIV cycles and then
// advances the window by one character.
module segment_text_scroller #(
  parameter int          MSG_DEPTH  = 32,
  parameter int          NUM_DIGITS = 6,
  parameter int          SCROLL_DIV = 100,
  parameter logic [7:0]  BLANK      = 8'h20
) (
  input  logic                       clk,
  input  logic                       rst,        // asynchronous, active-low
  input  logic                       wr_en,
  input  logic [7:0]                 wr_char,
  output logic                       wr_ready,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  output logic                       busy,
  output logic [7:0]                 char_out,
  output logic                       load,
  output logic [2:0]                 digit_sel,
  output logic [$clog2(MSG_DEPTH):0] msg_len
);

  localparam int AW = $clog2(MSG_DEPTH);
  // Wide enough for offset + digit, which can reach just under twice the ring length.
  localparam int RW = $clog2(MSG_DEPTH + 2 * NUM_DIGITS) + 1;
  localparam int WW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_WAIT
  } state_e;

  state_e          state_q;
  logic            gap_q;        // 0: next UPDATE cycle is a LOAD, 1: it is a GAP
  logic [2:0]      digit_q;      // digit being emitted in the current frame
  logic [RW-1:0]   offset_q;     // window start position within the ring
  logic [WW-1:0]   wait_q;       // remaining WAIT cycles minus one
  logic [AW:0]     msg_len_q;
  logic [7:0]      char_q;
  logic            load_q;
  logic [2:0]      digit_sel_q;

  logic [7:0]      msg_buf [MSG_DEPTH];

  logic [RW-1:0]   ring_len;
  logic [RW-1:0]   idx_sum;
  logic [RW-1:0]   idx;
  logic [7:0]      win_char;
  logic            write_accept;

  // Writes only land in IDLE with room left; clear and start outrank them.
  assign wr_ready     = (state_q == S_IDLE) && (msg_len_q < (AW+1)'(MSG_DEPTH));
  assign write_accept = wr_en && wr_ready && !clear && !start;

  // Window character for the current digit: ring index, then blank past the message.
  assign ring_len = RW'(msg_len_q) + RW'(NUM_DIGITS);
  assign idx_sum  = offset_q + RW'(digit_q);
  assign idx      = (idx_sum >= ring_len) ? (idx_sum - ring_len) : idx_sum;
  assign win_char = (idx < RW'(msg_len_q)) ? msg_buf[idx[AW-1:0]] : BLANK;

  assign busy      = (state_q != S_IDLE);
  assign char_out  = char_q;
  assign load      = load_q;
  assign digit_sel = digit_sel_q;
  assign msg_len   = msg_len_q;

  // Message storage: append at the current length.
  // NOTE: the buffer is deliberately left out of reset; msg_len alone says
  // which entries are valid, so clearing the array would only cost area.
  always_ff @(posedge clk) begin
    if (write_accept) begin
      msg_buf[msg_len_q[AW-1:0]] <= wr_char;
    end
  end

  // Control FSM with registered display outputs.
  // NOTE: every register here uses non-blocking assignment so that all
  // branches see the pre-edge values of state_q, digit_q and offset_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gap_q       <= 1'b0;
      digit_q     <= '0;
      offset_q    <= '0;
      wait_q      <= '0;
      msg_len_q   <= '0;
      char_q      <= BLANK;
      load_q      <= 1'b0;
      digit_sel_q <= '0;
    end else if (stop && state_q != S_IDLE) begin
      // Abort: drop the offset so the next start begins at the first character.
      state_q  <= S_IDLE;
      load_q   <= 1'b0;
      gap_q    <= 1'b0;
      digit_q  <= '0;
      offset_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          load_q <= 1'b0;
          if (clear) begin
            msg_len_q <= '0;
          end else if (start) begin
            if (!stop && msg_len_q != '0) begin
              state_q  <= S_UPDATE;
              gap_q    <= 1'b0;
              digit_q  <= '0;
              offset_q <= '0;
            end
          end else if (write_accept) begin
            msg_len_q <= msg_len_q + 1'b1;
          end
        end

        S_UPDATE: begin
          if (!gap_q) begin
            load_q      <= 1'b1;
            char_q      <= win_char;
            digit_sel_q <= digit_q;
            gap_q       <= 1'b1;
          end else begin
            load_q <= 1'b0;
            gap_q  <= 1'b0;
            if (digit_q == 3'(NUM_DIGITS - 1)) begin
              state_q <= S_WAIT;
              digit_q <= '0;
              wait_q  <= WW'(SCROLL_DIV - 1);
            end else begin
              digit_q <= digit_q + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (wait_q == '0) begin
            state_q  <= S_UPDATE;
            offset_q <= (offset_q + 1'b1 == ring_len) ? '0 : offset_q + 1'b1;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/segment_text_scroller.md
# segment_text_scroller

Upstream feeder for `sixteen_segment_display`. It holds an ASCII message in an internal buffer and scrolls a NUM_DIGITS-wide window across it. The message is followed by NUM_DIGITS blank characters before it wraps. For every window position it issues one `load` pulse per digit on the display's `char_in`/`load`/`digit_sel` interface, then waits a programmable number of cycles before advancing the window by one character.

## Interface
- MSG_DEPTH, 32: message buffer capacity in characters (power of 2, ≥ 2).
- NUM_DIGITS, 6: number of display digits driven; must be ≤ 8 (3-bit `digit_sel`).
- SCROLL_DIV, 100: idle cycles between the end of one frame update and the start of the next (≥ 1).
- BLANK, 8'h20: pad character emitted past the end of the message.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  append `wr_char` to the buffer; accepted only when `wr_ready` = 1.
- wr_char  in  8  ASCII character to append.
- wr_ready  out  1  combinational: state = IDLE and msg_len < MSG_DEPTH.
- clear  in  1  empties the buffer (IDLE only).
- start  in  1  begins scrolling from offset 0 (IDLE only, msg_len > 0).
- stop  in  1  aborts scrolling from any state.
- busy  out  1  high in every state other than IDLE.
- char_out  out  8  character to the display (`char_in`).
- load  out  1  one-cycle write strobe to the display.
- digit_sel  out  3  target digit for `char_out`.
- msg_len  out  $clog2(MSG_DEPTH)+1  current message length.

## Operation
- States:
  - IDLE: accepts writes, clear and start.
  - UPDATE: emits one frame.
  - WAIT: counts down SCROLL_DIV.
- Ring length L = msg_len + NUM_DIGITS.
- Window character for digit d at offset o:
  - i = (o + d) mod L.
  - char = buf[i] when i < msg_len, otherwise BLANK.
- IDLE input priority in one cycle: clear > start > wr_en. A lower-priority request in the same cycle is dropped.
- clear sets msg_len = 0. Buffer contents are not erased.
- start with msg_len = 0 is ignored; the block stays in IDLE.
- Accepted write: buf[msg_len] ← wr_char; msg_len increments.
- wr_en while wr_ready = 0 is ignored.
- UPDATE runs a LOAD/GAP pair for each d = 0..NUM_DIGITS-1:
  - LOAD: load = 1, digit_sel = d, char_out = window char.
  - GAP: load = 0.
  - Total UPDATE duration: 2·NUM_DIGITS cycles.
- WAIT lasts SCROLL_DIV cycles. At the end, offset ← (offset + 1) mod L, then UPDATE begins.
- stop: next state is IDLE and load returns to 0 at the next edge. Offset is discarded; the next start begins at offset 0. stop has priority over start.
- msg_len and the buffer cannot change while busy.

## Timing
- Reset values:
  - state IDLE, offset 0, msg_len 0.
  - busy 0, load 0, digit_sel 0, char_out BLANK.
  - wr_ready 1.
- char_out, load and digit_sel are registered. char_out and digit_sel hold their last value outside LOAD cycles.
- start sampled at edge N:
  - busy = 1 from edge N.
  - For digit d, load = 1 between edges N+1+2d and N+2+2d.
  - Last load pulse ends at edge N+2·NUM_DIGITS.
  - WAIT spans SCROLL_DIV cycles.
  - Next frame's digit-0 load rises at edge N+2·NUM_DIGITS+SCROLL_DIV+1.
- stop sampled at edge M: load = 0 and busy = 0 from edge M.
- Write accepted at edge W: msg_len updates at W and wr_ready reflects the new length in the same cycle.
- Asserting rst mid-frame forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- **Basic frame.** Reset, write "HELLO!", SCROLL_DIV = 4, pulse start.
  - Six load pulses, two cycles apart, carrying digit_sel 0..5 with chars 'H','E','L','L','O','!'.
  - Second frame carries 'E','L','L','O','!',8'h20.
- **Wrap-around.** "HELLO!" scrolling.
  - Frame 7 (offset 6) is six BLANKs.
  - Frame 13 (offset 12 mod 12 = 0) is "HELLO!" again.
- **Short message.** Write "HI", start.
  - Frame 0: 'H','I',BLANK×4.
  - Frame 1: 'I',BLANK×5.
  - Ring length is 8; frame 8 equals frame 0.
- **Buffer full.** Write 33 characters with MSG_DEPTH = 32.
  - msg_len = 32; wr_ready drops after the 32nd write; the 33rd is ignored.
  - clear then gives msg_len = 0 and wr_ready = 1.
- **Stop and priority.**
  - stop during digit 2 of a frame: load = 0 and busy = 0 at the next edge, no further pulses; a restart begins at 'H'.
  - start with msg_len = 0: busy stays 0.
  - start and stop in the same cycle: stays IDLE.
  - clear and wr_en in the same cycle: msg_len = 0.
- **Asynchronous reset.** Assert rst between clock edges during WAIT.
  - Outputs reach reset values before the next edge; msg_len = 0.
